// File: rtl/taxi_sync_reset_seq_if.sv
// Channel-reset bundle for taxi_sync_reset_seq.
// slave: the sequencer (drives rst_out/ready). master: the consumer (drives req).
interface taxi_sync_reset_seq_if #(
    parameter int unsigned CH = 4
);
    logic [CH-1:0] req;
    logic [CH-1:0] rst_out;
    logic          ready;

    modport master (
        output req,
        input  rst_out,
        input  ready
    );

    modport slave (
        input  req,
        output rst_out,
        output ready
    );
endinterface

// File: rtl/taxi_sync_reset_seq.sv
// Multi-channel reset sequencer with integrated release synchronizer.
// The asynchronous master reset is synchronized on release, then all channels
// are held for STRETCH cycles and released one by one, DELAY cycles apart.
// Optional soft-reset requests are enabled by defining TAXI_SYNC_RESET_SEQ_SOFT_EN.
module taxi_sync_reset_seq #(
    parameter int unsigned N       = 2,
    parameter int unsigned CH      = 4,
    parameter int unsigned STRETCH = 8,
    parameter int unsigned DELAY   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    taxi_sync_reset_seq_if.slave  bus
);
    localparam int unsigned MaxCnt = (STRETCH > DELAY) ? STRETCH : DELAY;
    localparam int unsigned CW     = $clog2(MaxCnt + 1);
    localparam int unsigned NW     = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [CW-1:0] StretchLast = CW'(STRETCH - 1);
    localparam logic [CW-1:0] DelayLast   = CW'(DELAY - 1);
    localparam logic [NW-1:0] LastCh      = NW'(CH - 1);

    typedef enum logic [1:0] {StHold, StRel, StRun} state_e;

    logic [N-1:0]  sync_q, sync_d;
    logic          sync_rst;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] nxt_q, nxt_d;
    logic [CH-1:0] rst_out_q, rst_out_d;
    logic          ready_q, ready_d;

    // Release synchronizer: shift zeros in once the master reset lets go.
    always_comb sync_d = {sync_q[N-2:0], 1'b0};

    // Discrete async-set flops; the set input keeps them out of shift-register primitives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_rst = sync_q[N-1];

`ifdef TAXI_SYNC_RESET_SEQ_SOFT_EN
    logic          req_any;
    logic [NW-1:0] soft_k;
    logic          soft_hit;
    logic          soft_hold;

    // Lowest requesting channel wins.
    always_comb begin
        req_any = 1'b0;
        soft_k  = '0;
        for (int i = int'(CH) - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                req_any = 1'b1;
                soft_k  = NW'(i);
            end
        end
    end

    // Restart only if the requested channel is already released; a request on the
    // channel being stretched keeps the stretch counter parked at zero.
    assign soft_hit  = req_any && ((state_q == StRun) || (soft_k < nxt_q));
    assign soft_hold = req_any && (state_q == StHold) && (soft_k == nxt_q);
`else
    logic unused_req;
    assign unused_req = ^bus.req;
`endif

    // Sequencer next state: stretch, then release one channel per DELAY window.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nxt_d     = nxt_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        if (!sync_rst) begin
            case (state_q)
                StHold, StRel: begin
                    if (cnt_q == ((state_q == StHold) ? StretchLast : DelayLast)) begin
                        for (int i = 0; i < int'(CH); i++) begin
                            if (NW'(i) == nxt_q) begin
                                rst_out_d[i] = 1'b0;
                            end
                        end
                        cnt_d = '0;
                        if (nxt_q == LastCh) begin
                            state_d = StRun;
                            ready_d = 1'b1;
                        end else begin
                            state_d = StRel;
                            nxt_d   = nxt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    rst_out_d = '0;
                    ready_d   = 1'b1;
                end
                default: state_d = StHold;
            endcase
`ifdef TAXI_SYNC_RESET_SEQ_SOFT_EN
            if (soft_hit) begin
                for (int i = 0; i < int'(CH); i++) begin
                    if (NW'(i) >= soft_k) begin
                        rst_out_d[i] = 1'b1;
                    end
                end
                ready_d = 1'b0;
                nxt_d   = soft_k;
                cnt_d   = '0;
                state_d = StHold;
            end else if (soft_hold) begin
                cnt_d = '0;
            end
`endif
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StHold;
            cnt_q     <= '0;
            nxt_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nxt_q     <= nxt_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.rst_out = rst_out_q;
    assign bus.ready   = ready_q;
endmodule

// File: tb/tb_taxi_sync_reset_seq.sv
// Directed bench for taxi_sync_reset_seq: default instance plus a minimal
// N=3/CH=1/STRETCH=1/DELAY=1 instance sharing clock and master reset.
module tb_taxi_sync_reset_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    taxi_sync_reset_seq_if #(.CH(4)) if0 ();
    taxi_sync_reset_seq_if #(.CH(1)) if1 ();

    taxi_sync_reset_seq #(.N(2), .CH(4), .STRETCH(8), .DELAY(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    taxi_sync_reset_seq #(.N(3), .CH(1), .STRETCH(1), .DELAY(1)) u_dut_min (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    int checks = 0;
    int failures = 0;

    int edge_n;
    int fall_edge [4];
    int ready_edge;
    int min_fall_edge;
    int min_ready_edge;
    int mono_err;
    int nfall;
    logic [3:0] prev_out = 4'hf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Rising-edge count since the last master-reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    // Mid-cycle monitor: first release edges, ordering and one-fall-per-edge.
    always @(negedge clk) begin
        if (rst_n) begin
            nfall = 0;
            for (int i = 0; i < 4; i++) begin
                if (prev_out[i] && !if0.rst_out[i]) nfall++;
                if (fall_edge[i] < 0 && !if0.rst_out[i]) fall_edge[i] = edge_n;
                if (i > 0 && !if0.rst_out[i] && if0.rst_out[i-1]) mono_err++;
            end
            if (nfall > 1) mono_err++;
            if (ready_edge < 0 && if0.ready) ready_edge = edge_n;
            if (min_fall_edge < 0 && !if1.rst_out[0]) min_fall_edge = edge_n;
            if (min_ready_edge < 0 && if1.ready) min_ready_edge = edge_n;
        end
        prev_out = if0.rst_out;
    end

    task automatic clear_mon();
        for (int i = 0; i < 4; i++) fall_edge[i] = -1;
        ready_edge = -1;
        min_fall_edge = -1;
        min_ready_edge = -1;
        mono_err = 0;
    endtask

    // Leaves time at posedge+1 of edge k.
    task automatic wait_edge(input int k);
        int guard = 0;
        while (edge_n < k && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (edge_n < k) check("wait_bound", edge_n, k);
    endtask

    // Assert master reset for a few cycles and release mid-cycle.
    task automatic reset_release();
        rst_n = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #3;
        clear_mon();
        rst_n = 1'b1;
    endtask

    task automatic check_timing(input string pfx);
        for (int i = 0; i < 4; i++) check({pfx, "_fall"}, fall_edge[i], 10 + 16 * i);
        check({pfx, "_ready_edge"}, ready_edge, 58);
        check({pfx, "_min_fall"}, min_fall_edge, 4);
        check({pfx, "_min_ready"}, min_ready_edge, 4);
        check({pfx, "_order"}, mono_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        if0.req = '0;
        if1.req = '0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_in_reset", if0.rst_out, 4'hf);
        check("ready_in_reset", if0.ready, 0);
        check("min_rst_out_in_reset", if1.rst_out, 1);
        check("min_ready_in_reset", if1.ready, 0);

        // Run A: full default sequence.
        reset_release();
        wait_edge(9);
        check("a_hold_edge9", if0.rst_out, 4'hf);
        wait_edge(26);
        check("a_edge26", if0.rst_out, 4'b1100);
        check("a_ready_edge26", if0.ready, 0);
        wait_edge(60);
        check("a_run_out", if0.rst_out, 0);
        check_timing("a");

        // Run B: asynchronous pulse mid-sequence at edge 30.
        reset_release();
        wait_edge(30);
        check("b_pre_pulse", if0.rst_out, 4'b1100);
        #2;
        rst_n = 1'b0;
        clear_mon();
        #1;
        check("b_async_rst_out", if0.rst_out, 4'hf);
        check("b_async_ready", if0.ready, 0);
        #3;
        rst_n = 1'b1;
        wait_edge(60);
        check_timing("b");

`ifdef TAXI_SYNC_RESET_SEQ_SOFT_EN
        // Soft reset of channel 2 from RUN, held for one sampled edge.
        e = edge_n + 1;
        if0.req = 4'b0100;
        wait_edge(e);
        if0.req = '0;
        check("s_req_rst_out", if0.rst_out, 4'b1100);
        check("s_req_ready", if0.ready, 0);
        wait_edge(e + 7);
        check("s_stretch_edge7", if0.rst_out, 4'b1100);
        wait_edge(e + 8);
        check("s_rel2", if0.rst_out, 4'b1000);
        wait_edge(e + 23);
        check("s_hold3", if0.rst_out, 4'b1000);
        wait_edge(e + 24);
        check("s_rel3", if0.rst_out, 0);
        check("s_ready", if0.ready, 1);

        // Run C: restart from REL with nxt=2, then an ignored request.
        reset_release();
        wait_edge(30);
        if0.req = 4'b1010;
        wait_edge(31);
        if0.req = '0;
        check("c_restart_out", if0.rst_out, 4'b1110);
        wait_edge(38);
        check("c_stretch", if0.rst_out, 4'b1110);
        wait_edge(39);
        check("c_rel1", if0.rst_out, 4'b1100);
        wait_edge(41);
        if0.req = 4'b1000;
        wait_edge(42);
        if0.req = '0;
        check("c_ignored", if0.rst_out, 4'b1100);
        wait_edge(54);
        check("c_hold2", if0.rst_out, 4'b1100);
        wait_edge(55);
        check("c_rel2", if0.rst_out, 4'b1000);
        wait_edge(71);
        check("c_rel3", if0.rst_out, 0);
        check("c_ready", if0.ready, 1);
`else
        // Requests are ignored in RUN.
        e = edge_n;
        if0.req = 4'hf;
        wait_edge(e + 1);
        check("n_run_out_1", if0.rst_out, 0);
        check("n_run_ready_1", if0.ready, 1);
        wait_edge(e + 20);
        check("n_run_out_20", if0.rst_out, 0);
        check("n_run_ready_20", if0.ready, 1);

        // Requests are ignored during the sequence as well.
        reset_release();
        wait_edge(60);
        check_timing("n");
        if0.req = '0;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
